// File: rtl/z80_alu16_seq_pkg.sv
// z80_alu16_seq_pkg: mode codes, F-register bit indices and FSM states shared by the sequential 16-bit ALU
package z80_alu16_seq_pkg;
    typedef enum logic [1:0] {
        ALU16_ADD = 2'b00,
        ALU16_ADC = 2'b01,
        ALU16_SBC = 2'b10,
        ALU16_SUB = 2'b11
    } alu16_mode_e;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam int FLAG_C_NUM = 0;
    localparam int FLAG_N_NUM = 1;
    localparam int FLAG_V_NUM = 2;
    localparam int FLAG_3_NUM = 3;
    localparam int FLAG_H_NUM = 4;
    localparam int FLAG_5_NUM = 5;
    localparam int FLAG_Z_NUM = 6;
    localparam int FLAG_S_NUM = 7;
endpackage

// File: rtl/z80_alu16_seq_if.sv
// z80_alu16_seq_if: start/done request bus between the execute sequencer (master) and the ALU (slave)
interface z80_alu16_seq_if
    import z80_alu16_seq_pkg::*;
#(parameter int WIDTH = 16);
    logic             start;
    alu16_mode_e      mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       f_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [7:0]       f_out;
    modport master (output start, mode, a, b, f_in, input busy, done, result, f_out);
    modport slave (input start, mode, a, b, f_in, output busy, done, result, f_out);
endinterface

// File: rtl/z80_alu16_seq_slice.sv
// z80_alu16_seq_slice: CHUNK-bit adder returning sum, carry out and the carry into its MSB
module z80_alu16_seq_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o,
    output logic             c_msb_o
);
    always_comb begin
        {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
        c_msb_o = sum_o[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
    end
endmodule

// File: rtl/z80_alu16_seq.sv
// z80_alu16_seq: multi-cycle ADD/ADC/SBC/SUB on WIDTH-bit operands, CHUNK bits per clock LSB first,
// producing the result and the full Z80 F register.
module z80_alu16_seq
    import z80_alu16_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHUNK    = 4,
    parameter int UNDOC_XY = 0
) (
    input logic            clk,
    input logic            reset_n,
    z80_alu16_seq_if.slave bus
);
    localparam int N      = WIDTH / CHUNK;
    localparam int CW     = (N > 1) ? $clog2(N) : 1;
    localparam int HC_IDX = (WIDTH - 4) / CHUNK - 1;
    state_e           state_q;
    alu16_mode_e      mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
    logic [7:0]       fin_q, f_q, f_d;
    logic             carry_q, zacc_q, hc_q, busy_q, done_q;
    logic [CHUNK-1:0] sum;
    logic             co, c_msb, zacc_d, sub, last;
    // a_q/b_q shift right each cycle so the active slice is always in the low bits
    z80_alu16_seq_slice #(.CHUNK(CHUNK)) u_slice (
        .a_i     (a_q[CHUNK-1:0]),
        .b_i     (b_q[CHUNK-1:0]),
        .c_i     (carry_q),
        .sum_o   (sum),
        .c_o     (co),
        .c_msb_o (c_msb)
    );
    always_comb begin
        sub = mode_q[1];
        last = cnt_q == CW'(N - 1);
        result_d = {sum, result_q[WIDTH-1:CHUNK]};
        zacc_d = zacc_q & (sum == '0);
        f_d = fin_q;
        f_d[FLAG_C_NUM] = sub ? ~co : co;
        f_d[FLAG_N_NUM] = sub;
        f_d[FLAG_H_NUM] = sub ? ~hc_q : hc_q;
        f_d[FLAG_V_NUM] = (mode_q == ALU16_ADD) ? fin_q[FLAG_V_NUM] : c_msb ^ co;
        f_d[FLAG_S_NUM] = (mode_q == ALU16_ADD) ? fin_q[FLAG_S_NUM] : result_d[WIDTH-1];
        f_d[FLAG_Z_NUM] = (mode_q == ALU16_ADD) ? fin_q[FLAG_Z_NUM] : zacc_d;
        f_d[FLAG_5_NUM] = (UNDOC_XY != 0) ? result_d[WIDTH-3] : fin_q[FLAG_5_NUM];
        f_d[FLAG_3_NUM] = (UNDOC_XY != 0) ? result_d[WIDTH-5] : fin_q[FLAG_3_NUM];
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= ALU16_ADD;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            fin_q    <= '0;
            f_q      <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            hc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    mode_q  <= bus.mode;
                    a_q     <= bus.a;
                    b_q     <= bus.mode[1] ? ~bus.b : bus.b;
                    fin_q   <= bus.f_in;
                    zacc_q  <= 1'b1;
                    carry_q <= (bus.mode == ALU16_ADC) ? bus.f_in[FLAG_C_NUM] :
                               (bus.mode == ALU16_SBC) ? ~bus.f_in[FLAG_C_NUM] :
                               (bus.mode == ALU16_SUB);
                end
            end else begin
                a_q      <= a_q >> CHUNK;
                b_q      <= b_q >> CHUNK;
                result_q <= result_d;
                carry_q  <= co;
                zacc_q   <= zacc_d;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(HC_IDX)) hc_q <= co;
                if (last) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    f_q     <= f_d;
                end
            end
        end
    end
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.f_out  = f_q;
endmodule

// File: tb/tb_z80_alu16_seq.sv
// tb_z80_alu16_seq: scoreboard bench for a CHUNK=4 and a CHUNK=1/UNDOC_XY=1 instance against an arithmetic model
module tb_z80_alu16_seq;
    import z80_alu16_seq_pkg::*;
    typedef struct {logic [15:0] r; logic [7:0] f; int t;} exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int cyc = 0, checks = 0, errors = 0;
    int issued0 = 0, issued1 = 0, dones0 = 0, dones1 = 0;
    exp_t q0[$], q1[$];
    z80_alu16_seq_if #(.WIDTH(16)) bus0 ();
    z80_alu16_seq_if #(.WIDTH(16)) bus1 ();
    z80_alu16_seq #(.WIDTH(16), .CHUNK(4), .UNDOC_XY(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    z80_alu16_seq #(.WIDTH(16), .CHUNK(1), .UNDOC_XY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(logic [15:0] r, logic [7:0] f);
        exp_t e;
        e.r = r;
        e.f = f;
        e.t = 0;
        return e;
    endfunction

    // Reference: whole-word arithmetic, borrows by comparison, overflow from operand/result signs
    function automatic exp_t model(logic [1:0] m, logic [15:0] a, logic [15:0] b, logic [7:0] f, bit undoc);
        logic [31:0] r;
        logic [15:0] res;
        bit sub, ci, c, h, v, s, z;
        sub = m[1];
        ci = (m == 2'b01 || m == 2'b10) ? f[0] : 1'b0;
        if (!sub) begin
            r = 32'(a) + 32'(b) + 32'(ci);
            c = r > 32'hFFFF;
            h = (32'(a[11:0]) + 32'(b[11:0]) + 32'(ci)) > 32'hFFF;
            v = (a[15] == b[15]) && (r[15] != a[15]);
        end else begin
            r = 32'(a) - 32'(b) - 32'(ci);
            c = 32'(a) < 32'(b) + 32'(ci);
            h = 32'(a[11:0]) < 32'(b[11:0]) + 32'(ci);
            v = (a[15] != b[15]) && (r[15] != a[15]);
        end
        res = r[15:0];
        s = res[15];
        z = res == 16'h0;
        if (m == 2'b00) begin
            s = f[7];
            z = f[6];
            v = f[2];
        end
        return mk(res, {s, z, undoc ? res[13] : f[5], h, undoc ? res[11] : f[3], v, sub, c});
    endfunction

    task automatic issue(int u, logic [1:0] m, logic [15:0] a, logic [15:0] b, logic [7:0] f, exp_t e);
        if (u == 0) begin
            bus0.start = 1'b1; bus0.mode = alu16_mode_e'(m); bus0.a = a; bus0.b = b; bus0.f_in = f;
        end else begin
            bus1.start = 1'b1; bus1.mode = alu16_mode_e'(m); bus1.a = a; bus1.b = b; bus1.f_in = f;
        end
        @(posedge clk);
        #1;
        e.t = cyc;
        if (u == 0) begin
            bus0.start = 1'b0; q0.push_back(e); issued0++;
        end else begin
            bus1.start = 1'b0; q1.push_back(e); issued1++;
        end
    endtask

    task automatic wait_done(int u);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((u == 0) ? bus0.done : bus1.done) return;
        end
        checks++;
        errors++;
        $display("FAIL u%0d done timeout: got no done expected done within 40 cycles", u);
    endtask

    always @(negedge clk) begin
        if (bus0.done) begin
            exp_t e;
            dones0++;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u0 unexpected done: got done=1 expected done=0");
            end else begin
                e = q0.pop_front();
                chk("u0 result", 32'(bus0.result), 32'(e.r));
                chk("u0 f_out", 32'(bus0.f_out), 32'(e.f));
                chk("u0 latency", cyc - e.t, 4);
                chk("u0 busy at done", 32'(bus0.busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.done) begin
            exp_t e;
            dones1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1 unexpected done: got done=1 expected done=0");
            end else begin
                e = q1.pop_front();
                chk("u1 result", 32'(bus1.result), 32'(e.r));
                chk("u1 f_out", 32'(bus1.f_out), 32'(e.f));
                chk("u1 latency", cyc - e.t, 16);
            end
        end
    end

    logic [1:0]  dm [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
    logic [15:0] da [5] = '{16'h7FFF, 16'h0000, 16'h1234, 16'hFFFF, 16'h1000};
    logic [15:0] db [5] = '{16'h0000, 16'h0001, 16'h1233, 16'h0001, 16'h0001};
    logic [7:0]  df [5] = '{8'h01, 8'h00, 8'h01, 8'hC4, 8'h29};
    logic [15:0] dr [5] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0FFF};
    logic [7:0]  dfe[5] = '{8'h94, 8'h93, 8'h42, 8'hD5, 8'h3A};

    initial begin
        logic [15:0] ra, rb, pick [4];
        logic [1:0]  rm;
        logic [7:0]  rf;
        pick = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        bus0.start = 1'b0; bus0.mode = ALU16_ADD; bus0.a = '0; bus0.b = '0; bus0.f_in = '0;
        bus1.start = 1'b0; bus1.mode = ALU16_ADD; bus1.a = '0; bus1.b = '0; bus1.f_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus0.busy), 0);
        chk("reset done", 32'(bus0.done), 0);
        chk("reset result", 32'(bus0.result), 0);
        chk("reset f_out", 32'(bus0.f_out), 0);
        chk("u1 reset result", 32'(bus1.result), 0);
        reset_n = 1'b1;
        @(negedge clk);
        // directed vectors issued back-to-back, each start landing in the previous done cycle
        for (int i = 0; i < 5; i++) begin
            issue(0, dm[i], da[i], db[i], df[i], mk(dr[i], dfe[i]));
            chk("busy after start", 32'(bus0.busy), 1);
            wait_done(0);
        end
        repeat (3) @(negedge clk);
        chk("hold result", 32'(bus0.result), 32'h0FFF);
        chk("hold f_out", 32'(bus0.f_out), 32'h3A);
        issue(0, 2'b00, 16'h1111, 16'h2222, 8'h00, mk(16'h3333, 8'h00));
        @(negedge clk);
        bus0.start = 1'b1; bus0.mode = ALU16_SBC; bus0.a = 16'hFFFF; bus0.b = 16'hFFFF; bus0.f_in = 8'hFF;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(0);
        repeat (8) @(negedge clk);
        chk("one done per start", dones0, issued0);
        issue(0, 2'b00, 16'h1234, 16'h1111, 8'h00, mk(16'h2345, 8'h00));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        q0.delete();
        issued0--;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("abort busy", 32'(bus0.busy), 0);
        chk("abort result", 32'(bus0.result), 0);
        chk("abort f_out", 32'(bus0.f_out), 0);
        repeat (10) @(negedge clk);
        chk("abort no done", dones0, issued0);
        for (int i = 0; i < 40; i++) begin
            rm = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            rf = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(0, rm, ra, rb, rf, model(rm, ra, rb, rf, 1'b0));
            wait_done(0);
        end
        @(negedge clk);
        issue(1, 2'b00, 16'h2000, 16'h0800, 8'h00, mk(16'h2800, 8'h28));
        wait_done(1);
        for (int i = 0; i < 15; i++) begin
            rm = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rf = 8'($urandom);
            issue(1, rm, ra, rb, rf, model(rm, ra, rb, rf, 1'b1));
            wait_done(1);
        end
        repeat (4) @(negedge clk);
        chk("u0 done count", dones0, issued0);
        chk("u1 done count", dones1, issued1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
